// File: rtl/bus_uart_tx.sv
`default_nettype none
// ============================================================================
// Module   : bus_uart_tx
// Purpose  : Memory-mapped 8N1 UART transmitter with a TX FIFO and a status register.
// Revision : 1.0  initial release
// ============================================================================
module bus_uart_tx #(
  parameter logic [31:0] BASE_ADDR    = 32'h40000018,
  parameter int          CLKS_PER_BIT = 868,
  parameter int          FIFO_DEPTH   = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        Device_Read,
  input  logic        Device_Write,
  input  logic [31:0] MemBus_Address,
  input  logic [31:0] MemBus_Write_Data,
  output logic [31:0] Device_Read_Data,
  output logic        uart_tx
);

  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int BAUD_W = $clog2(CLKS_PER_BIT + 1);
  localparam logic [BAUD_W-1:0] C_BAUD_MAX = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0]  C_FULL_CNT = CNT_W'(FIFO_DEPTH);
  localparam logic [31:0]       C_STATUS_ADDR = BASE_ADDR + 32'd4;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  state_t              r_state, w_state_next;
  logic [BAUD_W-1:0]   r_baud, w_baud_next;
  logic [2:0]          r_bit, w_bit_next;
  logic [7:0]          r_shift, w_shift_next;
  logic                r_tx, w_tx_next;
  logic                w_pop;

  logic [7:0]          r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]    r_wr_ptr, r_rd_ptr;
  logic [CNT_W-1:0]    r_count;
  logic                r_ovf;

  logic w_sel_txd, w_sel_stat, w_full, w_empty, w_busy;
  logic w_push_req, w_push, w_baud_done;
  logic w_unused_ok;

  assign w_sel_txd   = (MemBus_Address == BASE_ADDR);
  assign w_sel_stat  = (MemBus_Address == C_STATUS_ADDR);
  assign w_full      = (r_count == C_FULL_CNT);
  assign w_empty     = (r_count == '0);
  assign w_busy      = (r_state != S_IDLE);
  assign w_baud_done = (r_baud == C_BAUD_MAX);
  assign w_push_req  = Device_Write && w_sel_txd;
  // A full FIFO still accepts a byte when the head leaves on the same edge.
  assign w_push      = w_push_req && (!w_full || w_pop);
  assign w_unused_ok = &{1'b0, MemBus_Write_Data[31:8]};

  assign Device_Read_Data = (Device_Read && w_sel_stat)
                          ? {16'b0, 8'(r_count), 4'b0, r_ovf, w_empty, w_full, w_busy}
                          : 32'h0;
  assign uart_tx = r_tx;

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= MemBus_Write_Data[7:0];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_ovf    <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
      if (w_push_req && !w_push)
        r_ovf <= 1'b1;
      else if (Device_Write && w_sel_stat && MemBus_Write_Data[3])
        r_ovf <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_baud  <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_tx    <= 1'b1;
    end else begin
      r_state <= w_state_next;
      r_baud  <= w_baud_next;
      r_bit   <= w_bit_next;
      r_shift <= w_shift_next;
      r_tx    <= w_tx_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_baud_next  = r_baud;
    w_bit_next   = r_bit;
    w_shift_next = r_shift;
    w_pop        = 1'b0;
    w_tx_next    = 1'b1;
    case (r_state)
      S_IDLE: begin
        w_baud_next = '0;
        if (!w_empty) begin
          w_pop        = 1'b1;
          w_shift_next = r_mem[r_rd_ptr];
          w_state_next = S_START;
        end
      end
      S_START: begin
        if (w_baud_done) begin
          w_baud_next  = '0;
          w_bit_next   = '0;
          w_state_next = S_DATA;
        end else begin
          w_baud_next = r_baud + BAUD_W'(1);
        end
      end
      S_DATA: begin
        if (w_baud_done) begin
          w_baud_next = '0;
          if (r_bit == 3'd7) begin
            w_state_next = S_STOP;
          end else begin
            w_bit_next   = r_bit + 3'd1;
            w_shift_next = {1'b0, r_shift[7:1]};
          end
        end else begin
          w_baud_next = r_baud + BAUD_W'(1);
        end
      end
      S_STOP: begin
        if (w_baud_done) begin
          w_baud_next  = '0;
          w_state_next = S_IDLE;
        end else begin
          w_baud_next = r_baud + BAUD_W'(1);
        end
      end
      default: w_state_next = S_IDLE;
    endcase
    // Line level is registered from the next state so each bit starts on its edge.
    case (w_state_next)
      S_START: w_tx_next = 1'b0;
      S_DATA:  w_tx_next = w_shift_next[0];
      default: w_tx_next = 1'b1;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_bus_uart_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_bus_uart_tx
// Purpose  : Self-checking bench for bus_uart_tx with a byte scoreboard on uart_tx.
// Revision : 1.0  initial release
// ============================================================================
module tb_bus_uart_tx;

  localparam logic [31:0] C_BASE = 32'h40000018;
  localparam logic [31:0] C_STAT = 32'h4000001C;
  localparam int          C_CPB  = 4;

  logic        clk;
  logic        reset;
  logic        Device_Read;
  logic        Device_Write;
  logic [31:0] MemBus_Address;
  logic [31:0] MemBus_Write_Data;
  logic [31:0] Device_Read_Data;
  logic        uart_tx;

  int          checks = 0;
  int          errors = 0;
  int          cyc    = 0;
  bit          mon_en = 1'b1;
  logic [7:0]  sb[$];
  int          starts[$];

  bus_uart_tx #(
    .BASE_ADDR   (C_BASE),
    .CLKS_PER_BIT(C_CPB),
    .FIFO_DEPTH  (8)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .Device_Read      (Device_Read),
    .Device_Write     (Device_Write),
    .MemBus_Address   (MemBus_Address),
    .MemBus_Write_Data(MemBus_Write_Data),
    .Device_Read_Data (Device_Read_Data),
    .uart_tx          (uart_tx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic bus_write(input logic [31:0] addr, input logic [31:0] data);
    Device_Write      = 1'b1;
    MemBus_Address    = addr;
    MemBus_Write_Data = data;
    @(negedge clk);
    Device_Write      = 1'b0;
  endtask

  task automatic bus_read(input logic [31:0] addr, output logic [31:0] data);
    Device_Read    = 1'b1;
    MemBus_Address = addr;
    #1;
    data           = Device_Read_Data;
    Device_Read    = 1'b0;
  endtask

  // Decodes one frame per falling edge, sampling each bit at its midpoint.
  initial begin
    logic [7:0] b;
    forever begin
      @(negedge clk);
      if (mon_en && uart_tx === 1'b0) begin
        starts.push_back(cyc);
        repeat (2) @(negedge clk);
        check_val("start_bit", {31'b0, uart_tx}, 32'h0);
        for (int i = 0; i < 8; i++) begin
          repeat (C_CPB) @(negedge clk);
          b[i] = uart_tx;
        end
        repeat (C_CPB) @(negedge clk);
        check_val("stop_bit", {31'b0, uart_tx}, 32'h1);
        if (sb.size() == 0) check_val("unexpected_frame", {24'b0, b}, 32'hFFFF_FFFF);
        else                check_val("rx_byte", {24'b0, b}, {24'b0, sb.pop_front()});
      end
    end
  end

  initial begin
    logic [31:0] rd;
    int          busy_cnt;
    int          lows;
    int          guard;

    reset = 1'b0; Device_Read = 1'b0; Device_Write = 1'b0;
    MemBus_Address = '0; MemBus_Write_Data = '0;
    repeat (3) @(negedge clk);
    check_val("rst_tx", {31'b0, uart_tx}, 32'h1);
    reset = 1'b1;
    @(negedge clk);

    // 1: idle status after reset
    bus_read(C_STAT, rd);
    check_val("status_reset", rd, 32'h4);
    check_val("idle_tx", {31'b0, uart_tx}, 32'h1);

    // 2: single frame, busy window
    sb.push_back(8'h55);
    bus_write(C_BASE, 32'hFFFFFF55);
    busy_cnt = 0;
    for (int i = 0; i < 45; i++) begin
      bus_read(C_STAT, rd);
      if (rd[0]) busy_cnt++;
      @(negedge clk);
    end
    check_val("busy_cycles", busy_cnt, 32'd40);
    bus_read(C_STAT, rd);
    check_val("status_after_frame", rd, 32'h4);
    check_val("sb_drained_1", sb.size(), 32'd0);

    // 3: overflow with back-to-back frames
    starts.delete();
    for (int i = 0; i < 10; i++) begin
      if (i < 9) sb.push_back(8'(i));
      bus_write(C_BASE, 32'(i));
    end
    bus_read(C_STAT, rd);
    check_val("status_ovf_full", rd, 32'h0000_080B);

    // 4: clear overflow, FIFO untouched
    bus_write(C_STAT, 32'h8);
    bus_read(C_STAT, rd);
    check_val("status_ovf_clr", rd, 32'h0000_0803);

    guard = 0;
    while (sb.size() != 0 && guard < 1000) begin
      @(negedge clk);
      guard++;
    end
    check_val("drain_timeout", {31'b0, guard >= 1000}, 32'h0);
    repeat (5) @(negedge clk);
    check_val("frame_count", starts.size(), 32'd9);
    for (int i = 1; i < starts.size(); i++)
      check_val("frame_spacing", starts[i] - starts[i-1], 32'd41);
    bus_read(C_STAT, rd);
    check_val("status_idle_2", rd, 32'h4);

    // 5: reset mid-frame with bytes queued
    mon_en = 1'b0;
    for (int i = 0; i < 4; i++) bus_write(C_BASE, 32'h0);
    repeat (10) @(negedge clk);
    check_val("pre_reset_tx", {31'b0, uart_tx}, 32'h0);
    reset = 1'b0;
    #1;
    check_val("reset_tx_immediate", {31'b0, uart_tx}, 32'h1);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    bus_read(C_STAT, rd);
    check_val("status_post_reset", rd, 32'h4);
    mon_en = 1'b1;
    lows = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (uart_tx !== 1'b1) lows++;
    end
    check_val("no_frames_after_reset", lows, 32'd0);

    // 6: unmapped accesses
    bus_write(C_BASE + 32'd8, 32'hFFFF_FFA5);
    bus_read(C_BASE, rd);
    check_val("read_txd", rd, 32'h0);
    bus_read(C_BASE + 32'd8, rd);
    check_val("read_unmapped", rd, 32'h0);
    MemBus_Address = C_STAT;
    #1;
    check_val("status_no_strobe", Device_Read_Data, 32'h0);
    bus_read(C_STAT, rd);
    check_val("status_no_push", rd, 32'h4);
    lows = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (uart_tx !== 1'b1) lows++;
    end
    check_val("unmapped_tx_idle", lows, 32'd0);
    check_val("sb_final", sb.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
